// File: rtl/softreg_arbiter.sv
// Purpose: round-robin share of one softreg channel between N_REQ requesters; read responses routed to the issuer.
// Latency: downstream request 1 cycle after requester accept; read response 1 cycle after downstream response (or watchdog).
// Backpressure: one transaction outstanding; requests accepted only in IDLE; request/response fields held until handshake.
module softreg_arbiter #(
  parameter int N_REQ      = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int TIMEOUT    = 1024
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [N_REQ-1:0]              in_req_valid,
  output logic [N_REQ-1:0]              in_req_ready,
  input  logic [N_REQ*ADDR_WIDTH-1:0]   in_req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0]   in_req_wdata,
  input  logic [N_REQ-1:0]              in_req_wr,
  output logic [N_REQ-1:0]              in_resp_valid,
  input  logic [N_REQ-1:0]              in_resp_ready,
  output logic [DATA_WIDTH-1:0]         in_resp_rdata,
  output logic                          in_resp_err,
  output logic                          softreg_req_valid,
  input  logic                          softreg_req_ready,
  output logic [ADDR_WIDTH-1:0]         softreg_req_bits_addr,
  output logic [DATA_WIDTH-1:0]         softreg_req_bits_wdata,
  output logic                          softreg_req_bits_wr,
  input  logic                          softreg_resp_valid,
  output logic                          softreg_resp_ready,
  input  logic [DATA_WIDTH-1:0]         softreg_resp_bits_rdata,
  output logic [15:0]                   timeout_count
);

  localparam int GW = $clog2(N_REQ);
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, RETURN} state_t;

  state_t                state;
  logic [GW-1:0]         last_grant;
  logic [GW-1:0]         owner;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  wr_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic [WW-1:0]         wd_cnt;

  logic                  grant_vld;
  logic [GW-1:0]         grant_idx;
  int                    scan_idx;

  // Round-robin scan starting just after the last granted requester.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      scan_idx = (int'(last_grant) + k) % N_REQ;
      if (!grant_vld && in_req_valid[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = GW'(scan_idx);
      end
    end
  end

  // Accept is combinational in IDLE and forced low while reset is asserted.
  assign in_req_ready = (!reset && state == IDLE && grant_vld) ? (ONE_HOT0 << grant_idx) : '0;

  assign softreg_req_valid      = (state == ISSUE);
  assign softreg_req_bits_addr  = addr_q;
  assign softreg_req_bits_wdata = wdata_q;
  assign softreg_req_bits_wr    = wr_q;
  // Only WAIT_RESP consumes responses; strays elsewhere stay back-pressured.
  assign softreg_resp_ready     = (state == WAIT_RESP);

  assign in_resp_valid = (state == RETURN) ? (ONE_HOT0 << owner) : '0;
  assign in_resp_rdata = rdata_q;
  assign in_resp_err   = err_q;

  // Transaction FSM: grant, issue downstream, wait with watchdog, return response.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      last_grant    <= GW'(N_REQ - 1);
      owner         <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wr_q          <= 1'b0;
      rdata_q       <= '0;
      err_q         <= 1'b0;
      wd_cnt        <= '0;
      timeout_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            addr_q     <= in_req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_q    <= in_req_wdata[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
            wr_q       <= in_req_wr[grant_idx];
            owner      <= grant_idx;
            last_grant <= grant_idx;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (softreg_req_ready) begin
            wd_cnt <= '0;
            state  <= wr_q ? IDLE : WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          // A response in the timeout cycle wins over the watchdog.
          if (softreg_resp_valid) begin
            rdata_q <= softreg_resp_bits_rdata;
            err_q   <= 1'b0;
            state   <= RETURN;
          end else if (wd_cnt == WW'(TIMEOUT - 1)) begin
            rdata_q <= '1;
            err_q   <= 1'b1;
            if (timeout_count != 16'hFFFF) timeout_count <= timeout_count + 16'd1;
            state   <= RETURN;
          end else begin
            wd_cnt <= wd_cnt + WW'(1);
          end
        end
        RETURN: begin
          if (in_resp_ready[owner]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_softreg_arbiter.sv
// Purpose: self-checking bench for softreg_arbiter with scoreboard queues of expected requests/responses/grants.
// Latency: checks sampled 1 time unit after the rising clock edge.
// Backpressure: exercises stalls on both the downstream request and the requester response side.
module tb_softreg_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int TO = 8;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          wr;
  } req_t;

  typedef struct packed {
    logic [N-1:0]  vld;
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  logic              clock = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid, in_req_ready, req_wr, in_resp_valid, resp_ready;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic [DW-1:0]     in_resp_rdata;
  logic              in_resp_err;
  logic              sr_req_valid, sr_req_ready, sr_wr, sr_resp_valid, sr_resp_ready;
  logic [AW-1:0]     sr_addr;
  logic [DW-1:0]     sr_wdata, sr_resp_rdata;
  logic [15:0]       timeout_count;

  req_t exp_req[$];
  rsp_t exp_rsp[$];
  int   exp_grant[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clock = ~clock;

  softreg_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .in_req_valid(req_valid), .in_req_ready(in_req_ready),
    .in_req_addr(req_addr), .in_req_wdata(req_wdata), .in_req_wr(req_wr),
    .in_resp_valid(in_resp_valid), .in_resp_ready(resp_ready),
    .in_resp_rdata(in_resp_rdata), .in_resp_err(in_resp_err),
    .softreg_req_valid(sr_req_valid), .softreg_req_ready(sr_req_ready),
    .softreg_req_bits_addr(sr_addr), .softreg_req_bits_wdata(sr_wdata),
    .softreg_req_bits_wr(sr_wr),
    .softreg_resp_valid(sr_resp_valid), .softreg_resp_ready(sr_resp_ready),
    .softreg_resp_bits_rdata(sr_resp_rdata),
    .timeout_count(timeout_count)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid     = '0;
    req_wr        = '0;
    req_addr      = '0;
    req_wdata     = '0;
    resp_ready    = '0;
    sr_req_ready  = 1'b0;
    sr_resp_valid = 1'b0;
    sr_resp_rdata = '0;
  endtask

  task automatic drive_req(input int r, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w);
    req_valid[r]          = 1'b1;
    req_addr[r*AW +: AW]  = a;
    req_wdata[r*DW +: DW] = d;
    req_wr[r]             = w;
  endtask

  // Bounded wait for any requester accept; caller compares the result.
  task automatic wait_grant();
    int n;
    n = 0;
    while (in_req_ready == '0 && n < 10) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    req_valid = 2'b01;
    tick();
    tick();
    n_checks++;
    if ({in_req_ready, in_resp_valid, sr_req_valid, sr_resp_ready} !== '0)
      $display("FAIL reset_valids: got %b expected 0", {in_req_ready, in_resp_valid, sr_req_valid, sr_resp_ready});
    else n_pass++;
    n_checks++;
    if ({in_resp_rdata, in_resp_err, sr_addr, sr_wdata, sr_wr} !== '0)
      $display("FAIL reset_data: rdata=%h err=%b addr=%h wdata=%h wr=%b expected all 0", in_resp_rdata, in_resp_err, sr_addr, sr_wdata, sr_wr);
    else n_pass++;
    n_checks++;
    if (timeout_count !== 16'd0) $display("FAIL reset_timeout_count: got %0d expected 0", timeout_count);
    else n_pass++;
    req_valid = '0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_write();
    req_t er;
    drive_req(0, 32'h10, 64'hDEADBEEF, 1'b1);
    sr_req_ready = 1'b1;
    exp_req.push_back('{addr: 32'h10, wdata: 64'hDEADBEEF, wr: 1'b1});
    #1;
    n_checks++;
    if (in_req_ready !== 2'b01) $display("FAIL write_accept: got %b expected 01", in_req_ready);
    else n_pass++;
    tick();
    req_valid = '0;
    er = exp_req.pop_front();
    n_checks++;
    if ({sr_req_valid, sr_addr, sr_wdata, sr_wr} !== {1'b1, er.addr, er.wdata, er.wr})
      $display("FAIL write_issue: got v=%b a=%h d=%h w=%b expected v=1 a=%h d=%h w=%b", sr_req_valid, sr_addr, sr_wdata, sr_wr, er.addr, er.wdata, er.wr);
    else n_pass++;
    tick();
    n_checks++;
    if ({sr_req_valid, in_resp_valid, sr_resp_ready} !== 4'b0)
      $display("FAIL write_done: got req_v=%b resp_v=%b resp_rdy=%b expected all 0", sr_req_valid, in_resp_valid, sr_resp_ready);
    else n_pass++;
    sr_req_ready = 1'b0;
  endtask

  task automatic test_read_roundtrip();
    req_t er;
    rsp_t ep;
    drive_req(1, 32'h20, 64'h0, 1'b0);
    resp_ready   = 2'b00;
    sr_req_ready = 1'b1;
    exp_req.push_back('{addr: 32'h20, wdata: 64'h0, wr: 1'b0});
    exp_rsp.push_back('{vld: 2'b10, rdata: 64'h1234, err: 1'b0});
    #1;
    n_checks++;
    if (in_req_ready !== 2'b10) $display("FAIL read_accept: got %b expected 10", in_req_ready);
    else n_pass++;
    tick();
    req_valid = '0;
    er = exp_req.pop_front();
    n_checks++;
    if ({sr_req_valid, sr_addr, sr_wr} !== {1'b1, er.addr, er.wr})
      $display("FAIL read_issue: got v=%b a=%h w=%b expected v=1 a=%h w=%b", sr_req_valid, sr_addr, sr_wr, er.addr, er.wr);
    else n_pass++;
    tick();
    n_checks++;
    if (sr_resp_ready !== 1'b1) $display("FAIL read_wait_ready: got %b expected 1", sr_resp_ready);
    else n_pass++;
    tick();
    tick();
    sr_resp_valid = 1'b1;
    sr_resp_rdata = 64'h1234;
    tick();
    sr_resp_valid = 1'b0;
    sr_resp_rdata = '0;
    ep = exp_rsp.pop_front();
    n_checks++;
    if ({in_resp_valid, in_resp_rdata, in_resp_err} !== {ep.vld, ep.rdata, ep.err})
      $display("FAIL read_resp: got v=%b d=%h e=%b expected v=%b d=%h e=%b", in_resp_valid, in_resp_rdata, in_resp_err, ep.vld, ep.rdata, ep.err);
    else n_pass++;
    n_checks++;
    if (sr_resp_ready !== 1'b0) $display("FAIL read_resp_ready_low: got %b expected 0", sr_resp_ready);
    else n_pass++;
    resp_ready = 2'b01;
    tick();
    n_checks++;
    if (in_resp_valid !== 2'b10) $display("FAIL read_nonowner_ignored: got %b expected 10", in_resp_valid);
    else n_pass++;
    resp_ready = 2'b10;
    tick();
    n_checks++;
    if (in_resp_valid !== 2'b00) $display("FAIL read_resp_done: got %b expected 00", in_resp_valid);
    else n_pass++;
    resp_ready = 2'b00;
    sr_req_ready = 1'b0;
  endtask

  task automatic test_fairness();
    req_t er;
    int   e;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive_req(0, 32'h100, 64'hA0, 1'b1);
    drive_req(1, 32'h200, 64'hB1, 1'b1);
    sr_req_ready = 1'b1;
    for (int g = 0; g < 4; g++) begin
      exp_grant.push_back(g % 2);
      if (g % 2 == 0) exp_req.push_back('{addr: 32'h100, wdata: 64'hA0, wr: 1'b1});
      else            exp_req.push_back('{addr: 32'h200, wdata: 64'hB1, wr: 1'b1});
    end
    #1;
    for (int g = 0; g < 4; g++) begin
      wait_grant();
      e = exp_grant.pop_front();
      n_checks++;
      if (in_req_ready !== (2'b01 << e)) $display("FAIL fair_grant%0d: got %b expected requester %0d", g, in_req_ready, e);
      else n_pass++;
      tick();
      er = exp_req.pop_front();
      n_checks++;
      if ({sr_req_valid, sr_addr, sr_wdata} !== {1'b1, er.addr, er.wdata})
        $display("FAIL fair_issue%0d: got v=%b a=%h d=%h expected v=1 a=%h d=%h", g, sr_req_valid, sr_addr, sr_wdata, er.addr, er.wdata);
      else n_pass++;
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_timeout();
    rsp_t ep;
    int   n;
    bit   ok;
    drive_req(0, 32'h30, 64'h0, 1'b0);
    sr_req_ready = 1'b1;
    exp_rsp.push_back('{vld: 2'b01, rdata: {DW{1'b1}}, err: 1'b1});
    #1;
    wait_grant();
    n_checks++;
    if (in_req_ready !== 2'b01) $display("FAIL to_accept: got %b expected 01", in_req_ready);
    else n_pass++;
    tick();
    req_valid = '0;
    tick();
    n = 0;
    while (sr_resp_ready && n < 50) begin
      n++;
      tick();
    end
    n_checks++;
    if (n != TO) $display("FAIL to_wait_cycles: got %0d expected %0d", n, TO);
    else n_pass++;
    ep = exp_rsp.pop_front();
    n_checks++;
    if ({in_resp_valid, in_resp_rdata, in_resp_err} !== {ep.vld, ep.rdata, ep.err})
      $display("FAIL to_resp: got v=%b d=%h e=%b expected v=%b d=%h e=%b", in_resp_valid, in_resp_rdata, in_resp_err, ep.vld, ep.rdata, ep.err);
    else n_pass++;
    n_checks++;
    if (timeout_count !== 16'd1) $display("FAIL to_count: got %0d expected 1", timeout_count);
    else n_pass++;
    // Late response must stay back-pressured outside WAIT_RESP.
    sr_resp_valid = 1'b1;
    sr_resp_rdata = 64'h5555;
    resp_ready    = 2'b01;
    tick();
    resp_ready = 2'b00;
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (sr_resp_ready !== 1'b0 || in_resp_valid !== 2'b00) ok = 1'b0;
      tick();
    end
    n_checks++;
    if (!ok) $display("FAIL to_late_resp_blocked: got resp_ready=%b expected 0", sr_resp_ready);
    else n_pass++;
    sr_resp_valid = 1'b0;
    sr_resp_rdata = '0;
    // Response arriving in the final watchdog cycle wins.
    drive_req(1, 32'h38, 64'h0, 1'b0);
    exp_rsp.push_back('{vld: 2'b10, rdata: 64'h77, err: 1'b0});
    #1;
    wait_grant();
    tick();
    req_valid = '0;
    tick();
    for (int i = 0; i < TO - 1; i++) tick();
    sr_resp_valid = 1'b1;
    sr_resp_rdata = 64'h77;
    tick();
    sr_resp_valid = 1'b0;
    sr_resp_rdata = '0;
    ep = exp_rsp.pop_front();
    n_checks++;
    if ({in_resp_valid, in_resp_rdata, in_resp_err} !== {ep.vld, ep.rdata, ep.err})
      $display("FAIL to_edge_resp: got v=%b d=%h e=%b expected v=%b d=%h e=%b", in_resp_valid, in_resp_rdata, in_resp_err, ep.vld, ep.rdata, ep.err);
    else n_pass++;
    n_checks++;
    if (timeout_count !== 16'd1) $display("FAIL to_edge_count: got %0d expected 1", timeout_count);
    else n_pass++;
    resp_ready = 2'b10;
    tick();
    idle_inputs();
  endtask

  task automatic test_back_pressure();
    req_t er;
    rsp_t ep;
    bit   ok;
    sr_req_ready = 1'b0;
    drive_req(0, 32'h40, 64'h4444, 1'b0);
    exp_req.push_back('{addr: 32'h40, wdata: 64'h4444, wr: 1'b0});
    exp_rsp.push_back('{vld: 2'b01, rdata: 64'hABCD, err: 1'b0});
    #1;
    wait_grant();
    n_checks++;
    if (in_req_ready !== 2'b01) $display("FAIL bp_accept: got %b expected 01", in_req_ready);
    else n_pass++;
    tick();
    req_valid[0] = 1'b0;
    drive_req(1, 32'h50, 64'h0, 1'b1);
    er = exp_req.pop_front();
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if ({sr_req_valid, sr_addr, sr_wdata, sr_wr} !== {1'b1, er.addr, er.wdata, er.wr} || in_req_ready !== 2'b00) ok = 1'b0;
      tick();
    end
    n_checks++;
    if (!ok) $display("FAIL bp_req_hold: got v=%b a=%h d=%h rdy=%b expected held a=%h d=%h", sr_req_valid, sr_addr, sr_wdata, in_req_ready, er.addr, er.wdata);
    else n_pass++;
    sr_req_ready = 1'b1;
    tick();
    sr_req_ready  = 1'b0;
    sr_resp_valid = 1'b1;
    sr_resp_rdata = 64'hABCD;
    tick();
    sr_resp_valid = 1'b0;
    sr_resp_rdata = '0;
    ep = exp_rsp.pop_front();
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if ({in_resp_valid, in_resp_rdata, in_resp_err} !== {ep.vld, ep.rdata, ep.err} || in_req_ready !== 2'b00) ok = 1'b0;
      tick();
    end
    n_checks++;
    if (!ok) $display("FAIL bp_resp_hold: got v=%b d=%h e=%b rdy=%b expected v=%b d=%h", in_resp_valid, in_resp_rdata, in_resp_err, in_req_ready, ep.vld, ep.rdata);
    else n_pass++;
    resp_ready = 2'b01;
    #1;
    n_checks++;
    if (in_req_ready !== 2'b00) $display("FAIL bp_ready_indep: got %b expected 00", in_req_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (in_req_ready !== 2'b10) $display("FAIL bp_next_grant: got %b expected 10", in_req_ready);
    else n_pass++;
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_reset_midread();
    bit ok;
    sr_req_ready = 1'b1;
    drive_req(0, 32'h60, 64'h0, 1'b0);
    #1;
    wait_grant();
    tick();
    req_valid = '0;
    tick();
    n_checks++;
    if (sr_resp_ready !== 1'b1) $display("FAIL rst_mid_wait: got %b expected 1", sr_resp_ready);
    else n_pass++;
    drive_req(0, 32'h70, 64'h1, 1'b1);
    drive_req(1, 32'h80, 64'h2, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({in_req_ready, in_resp_valid, sr_req_valid, sr_resp_ready, in_resp_err, timeout_count} !== '0)
      $display("FAIL rst_mid_outputs: got rdy=%b rv=%b qv=%b qr=%b e=%b tc=%0d expected all 0", in_req_ready, in_resp_valid, sr_req_valid, sr_resp_ready, in_resp_err, timeout_count);
    else n_pass++;
    tick();
    reset = 1'b0;
    #1;
    n_checks++;
    if (in_req_ready !== 2'b01) $display("FAIL rst_mid_first_grant: got %b expected 01", in_req_ready);
    else n_pass++;
    idle_inputs();
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (in_resp_valid !== 2'b00) ok = 1'b0;
      tick();
    end
    n_checks++;
    if (!ok) $display("FAIL rst_mid_abandoned: got resp_valid=%b expected 00", in_resp_valid);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_roundtrip();
    test_fairness();
    test_timeout();
    test_back_pressure();
    test_reset_midread();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time budget, %0d/%0d passed", n_pass, n_checks);
    $fatal(1, "time budget exhausted");
  end

endmodule

// File: doc/softreg_arbiter.md
Name: softreg_arbiter

Overview:
- Shares the single softreg request/response channel of the shim between N_REQ requesters, e.g. the host-driven tick interface and an on-chip debug/config master.
- Round-robin arbitration with exactly one transaction outstanding.
- Routes each read response back to the requester that issued it.
- A watchdog terminates reads whose response never arrives, so no requester hangs.

Parameters:
- N_REQ, 2, number of requesters (>=2)
- ADDR_WIDTH, 32, softreg address width (matches SOFTREG_ADDR_WIDTH)
- DATA_WIDTH, 64, softreg data width (matches SOFTREG_DATA_WIDTH)
- TIMEOUT, 1024, cycles to wait for a read response before erroring (>=2)

Ports:
- clock  in  1  single clock domain
- reset  in  1  asynchronous, active-high reset
- in_req_valid  in  N_REQ  per-requester request valid
- in_req_ready  out  N_REQ  per-requester request accept (one-hot or zero)
- in_req_addr  in  N_REQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- in_req_wdata  in  N_REQ*DATA_WIDTH  packed write data
- in_req_wr  in  N_REQ  1=write, 0=read
- in_resp_valid  out  N_REQ  read response valid, one-hot or zero
- in_resp_ready  in  N_REQ  per-requester response accept
- in_resp_rdata  out  DATA_WIDTH  response data, shared by all requesters
- in_resp_err  out  1  response produced by timeout
- softreg_req_valid  out  1  downstream request valid
- softreg_req_ready  in  1  downstream request ready
- softreg_req_bits_addr  out  ADDR_WIDTH  downstream address
- softreg_req_bits_wdata  out  DATA_WIDTH  downstream write data
- softreg_req_bits_wr  out  1  downstream write flag
- softreg_resp_valid  in  1  downstream response valid
- softreg_resp_ready  out  1  downstream response ready
- softreg_resp_bits_rdata  in  DATA_WIDTH  downstream read data
- timeout_count  out  16  saturating count of timed-out reads

Behaviour:
- Reset (async, active-high):
  - State=IDLE; last_grant=N_REQ-1, so requester 0 has first priority.
  - All valid/ready outputs, data registers and timeout_count = 0.
  - An in-flight transaction is abandoned; no response is ever returned for it.
- States: IDLE, ISSUE, WAIT_RESP, RETURN.
- IDLE:
  - Winner = first i with in_req_valid[i], scanning last_grant+1, last_grant+2, ... modulo N_REQ.
  - in_req_ready[winner]=1 combinationally in the same cycle; all others 0.
  - On that edge: capture addr/wdata/wr and winner index into registers; last_grant<=winner; go to ISSUE.
  - No valid requesters: stay in IDLE, all in_req_ready=0.
- ISSUE:
  - softreg_req_valid=1; softreg_req_bits_* driven from registers and held stable until fire.
  - On softreg_req_ready: write goes to IDLE (writes get no requester response); read clears the watchdog counter and goes to WAIT_RESP.
  - Earliest downstream issue is 1 cycle after the requester handshake.
- WAIT_RESP:
  - softreg_resp_ready=1 here only; 0 in every other state, so stray responses are back-pressured and never consumed.
  - On softreg_resp_valid: capture rdata, err<=0, go to RETURN.
  - Otherwise the counter increments. When it reaches TIMEOUT-1 with no response: rdata<=all ones, err<=1, timeout_count increments (saturates at 16'hFFFF), go to RETURN.
  - A response arriving in the same cycle as the timeout takes priority: normal data, no error.
- RETURN:
  - in_resp_valid[owner]=1; in_resp_rdata and in_resp_err held stable.
  - On in_resp_ready[owner]: go to IDLE.
  - in_resp_ready of non-owners is ignored.
- Throughput: read takes at least 4 cycles requester-to-requester; write takes at least 2.
- Requests are never accepted outside IDLE.
- in_req_ready never depends on in_resp_ready.

Test Plan:
- Single write: req0 valid, addr=0x10, wdata=0xDEADBEEF, wr=1, softreg_req_ready=1 -> in_req_ready[0] same cycle; softreg_req_valid next cycle with addr 0x10 and that data; no in_resp_valid; back to IDLE after 2 cycles.
- Read round-trip: req1 reads addr 0x20; downstream responds with 0x1234 three cycles after fire -> in_resp_valid[1]=1, rdata=0x1234, err=0; in_resp_valid[0] stays 0.
- Fairness: req0 and req1 both continuously valid for 4 writes -> grant order 0,1,0,1 from reset.
- Timeout: TIMEOUT=8, read with softreg_resp_valid held 0 -> after 8 WAIT_RESP cycles in_resp_err=1, rdata=all ones, timeout_count=1. Then a late response: softreg_resp_ready stays 0 until the next read.
- Back-pressure: softreg_req_ready=0 for 5 cycles, then in_resp_ready=0 for 3 cycles -> req fields and response fields each held stable; no new grant until the response handshake completes.
- Reset mid-read (WAIT_RESP) -> all outputs 0 immediately; next grant goes to requester 0.
